pixel_line_feeder: RTL
======================

Name: pixel_line_feeder

Overview:
- Upstream stage of imageProcessingModule (Gaussian blur). Pulls raw grayscale pixels from a byte source (DMA/FIFO) and paces them into the blur block's slave stream.
- Pacing per frame: PRIME_LINES lines up front, then one line per blur interrupt, then PAD_LINES all-zero lines to flush the line buffers.
- Replaces bench-side sequencing with synthesizable RTL.

Parameters:
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- PRIME_LINES, 4, lines sent before the first interrupt is required
- PAD_LINES, 2, zero lines appended after the last image line (0 allowed)
- DATA_W, 8, pixel width

Ports:
- axi_clk  in  1  clock
- axi_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle frame start; ignored unless IDLE
- s_data_valid  in  1  source pixel valid
- s_data  in  DATA_W  source pixel
- s_data_ready  out  1  feeder accepts source pixel
- i_intr  in  1  blur-block interrupt; rising edge = one line credit
- o_data_valid  out  1  pixel valid to blur block
- o_data  out  DATA_W  pixel to blur block
- i_data_ready  in  1  blur block accepts pixel
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock, axi_clk; reset is axi_reset, synchronous and active-high.
- Reset values: all outputs 0. State IDLE. Credits, pixel counter, line counter and the i_intr edge register are all 0.
- States and transitions:
  - IDLE: go to PRIME on i_start.
  - PRIME: transfer PRIME_LINES*IMG_WIDTH source pixels, then go to WAIT.
  - WAIT: if lines_sent < IMG_HEIGHT and credits > 0, go to LINE; if lines_sent == IMG_HEIGHT, go to PAD_WAIT.
  - LINE: transfer IMG_WIDTH source pixels, then go to WAIT.
  - PAD_WAIT: if pad_sent == PAD_LINES, go to DONE; else if credits > 0, go to PAD.
  - PAD: emit IMG_WIDTH zero pixels without touching the source, then go to PAD_WAIT.
  - DONE: pulse o_done for one cycle, then go to IDLE.
- Credits:
  - Rising-edge detect on i_intr using a registered previous value.
  - 3-bit counter. Increment on edge; decrement on WAIT->LINE or PAD_WAIT->PAD.
  - Simultaneous increment and decrement leaves the count unchanged. Saturates at 7.
  - Edges that arrive during PRIME/LINE/PAD are kept, so back-to-back lines follow with no idle gap.
- Output stage: one registered entry.
  - s_data_ready = (PRIME or LINE) && beats_remaining > 0 && (!o_data_valid || i_data_ready).
  - A source handshake loads o_data and sets o_data_valid on the next edge; latency is 1 cycle.
  - o_data_valid && !i_data_ready: o_data held stable, no loss, no duplication.
  - In PAD, o_data = 0 with the same handshake rules; s_data_ready stays 0.
- Counters:
  - Pixel counter width $clog2(PRIME_LINES*IMG_WIDTH+1).
  - A phase ends when its last beat is accepted downstream, not when it is captured from the source.
  - lines_sent counts image lines, including primed lines.
- Boundaries:
  - PRIME_LINES >= IMG_HEIGHT: PRIME is clamped to IMG_HEIGHT lines and WAIT goes straight to PAD_WAIT.
  - i_start while busy: ignored.
  - Reset mid-frame: next cycle is IDLE, o_data_valid = 0, credits cleared; an in-flight pixel is dropped.

Optional Feature:
- FEEDER_STALL_CNT_EN, when defined:
  - Adds output o_stall_cycles[31:0].
  - Counts cycles with o_data_valid && !i_data_ready.
  - Cleared on reset and on i_start; saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pixel_feeder_pkg:
  - state enum feeder_state_t {IDLE, PRIME, WAIT, LINE, PAD_WAIT, PAD, DONE}
  - CREDIT_W = 3 and CREDIT_MAX = 7
- Sub-module feeder_credit_ctr: edge detect plus saturating up/down counter.
- The FSM, counters and output register stay in the top.

Test Plan:
- Use IMG_WIDTH=8, IMG_HEIGHT=8, PRIME_LINES=4, PAD_LINES=2. Source values increment from 0; i_data_ready=1 unless stated.
- Start -> exactly 32 beats with values 0..31 in order; then s_data_ready=0 and no further beats while i_intr stays low.
- One i_intr pulse after priming -> exactly 8 beats (32..39); credits return to 0; idle afterwards.
- i_data_ready toggling 1/0 every cycle during LINE -> 8 beats, no drops or duplicates; o_data stable in stall cycles. With FEEDER_STALL_CNT_EN, o_stall_cycles = number of stalled cycles.
- Two i_intr pulses during one LINE -> the next two lines follow back-to-back with no gap and no further i_intr.
- Full frame -> 64 image beats, then 2 pulses give 16 zero beats with s_data_ready=0; o_done pulses once; 80 beats total.
- axi_reset asserted mid-LINE -> next cycle o_data_valid=0, o_busy=0, credits=0; a new i_start restarts priming at the next source pixel.

Source files
------------

// File: rtl/pixel_feeder_pkg.sv
// pixel_feeder_pkg: shared types and constants for pixel_line_feeder.
//   feeder_state_t : frame sequencing states
//   CREDIT_W/MAX   : line-credit counter width and saturation value
package pixel_feeder_pkg;

  localparam int unsigned CREDIT_W   = 3;
  localparam int unsigned CREDIT_MAX = 7;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT,
    LINE,
    PAD_WAIT,
    PAD,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/feeder_credit_ctr.sv
// feeder_credit_ctr: line-credit counter fed by blur-block interrupts.
//   clk, reset : clock, synchronous active-high reset
//   intr       : interrupt level; each rising edge adds one credit
//   take       : consume one credit (only asserted while credits > 0)
//   credits    : current credit count, saturating at CREDIT_MAX
module feeder_credit_ctr
  import pixel_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                intr,
  input  logic                take,
  output logic [CREDIT_W-1:0] credits
);

  logic intrPrev;
  logic intrRise;

  assign intrRise = intr && !intrPrev;

  // An edge and a take in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      intrPrev <= 1'b0;
      credits  <= '0;
    end else begin
      intrPrev <= intr;
      if (intrRise && !take && credits != CREDIT_W'(CREDIT_MAX)) begin
        credits <= credits + CREDIT_W'(1);
      end else if (take && !intrRise) begin
        credits <= credits - CREDIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder: paces a raw pixel source into the Gaussian blur stream.
// Each frame sends PRIME_LINES lines, then one line per interrupt credit,
// then PAD_LINES all-zero lines (one credit each), then pulses o_done.
//   axi_clk, axi_reset : clock, synchronous active-high reset
//   i_start            : frame start, honoured only when idle
//   s_data_*           : source pixel stream (valid/ready)
//   i_intr             : blur-block interrupt, rising edge = one line credit
//   o_data_*, i_data_ready : pixel stream to the blur block
//   o_busy, o_done     : frame in progress / one-cycle completion pulse
// Optional macro FEEDER_STALL_CNT_EN adds o_stall_cycles, a saturating count
// of cycles with o_data_valid high and i_data_ready low.
module pixel_line_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned PAD_LINES   = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_start,
  input  logic              s_data_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_data_ready,
  input  logic              i_intr,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  output logic              o_busy,
  output logic              o_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  localparam int unsigned PRIME_EFF = (PRIME_LINES < IMG_HEIGHT) ? PRIME_LINES : IMG_HEIGHT;
  localparam int unsigned PIX_W     = $clog2(PRIME_LINES * IMG_WIDTH + 1);
  localparam int unsigned LINE_W    = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned PAD_W     = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;

  feeder_state_t         state;
  logic [PIX_W-1:0]      beatsRemaining;
  logic [LINE_W-1:0]     linesSent;
  logic [PAD_W-1:0]      padSent;
  logic [CREDIT_W-1:0]   credits;

  logic slotFree;
  logic srcLoad;
  logic padLoad;
  logic phaseEnd;
  logic hasCredit;
  logic imageDone;
  logic padDone;
  logic takeCredit;

  // Output register can take a new beat when empty or draining this cycle.
  assign slotFree     = !o_data_valid || i_data_ready;
  assign s_data_ready = (state == PRIME || state == LINE) && beatsRemaining != '0 && slotFree;
  assign srcLoad      = s_data_ready && s_data_valid;
  assign padLoad      = (state == PAD) && beatsRemaining != '0 && slotFree;
  // Phase completes once the last beat has left the output register.
  assign phaseEnd     = (beatsRemaining == '0) && slotFree;
  assign hasCredit    = credits != '0;
  assign imageDone    = linesSent == LINE_W'(IMG_HEIGHT);
  assign padDone      = padSent == PAD_W'(PAD_LINES);
  assign takeCredit   = hasCredit && (((state == WAIT) && !imageDone) ||
                                      ((state == PAD_WAIT) && !padDone));

  feeder_credit_ctr u_credit (
    .clk     (axi_clk),
    .reset   (axi_reset),
    .intr    (i_intr),
    .take    (takeCredit),
    .credits (credits)
  );

  // Frame sequencer, beat counters and the single-entry output register.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state          <= IDLE;
      beatsRemaining <= '0;
      linesSent      <= '0;
      padSent        <= '0;
      o_data_valid   <= 1'b0;
      o_data         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_done <= 1'b0;

      if (srcLoad) begin
        o_data       <= s_data;
        o_data_valid <= 1'b1;
      end else if (padLoad) begin
        o_data       <= '0;
        o_data_valid <= 1'b1;
      end else if (i_data_ready) begin
        o_data_valid <= 1'b0;
      end

      if (srcLoad || padLoad) begin
        beatsRemaining <= beatsRemaining - PIX_W'(1);
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state          <= PRIME;
            beatsRemaining <= PIX_W'(PRIME_EFF * IMG_WIDTH);
            linesSent      <= '0;
            padSent        <= '0;
            o_busy         <= 1'b1;
          end
        end
        PRIME: begin
          if (phaseEnd) begin
            state     <= WAIT;
            linesSent <= LINE_W'(PRIME_EFF);
          end
        end
        WAIT: begin
          if (imageDone) begin
            state <= PAD_WAIT;
          end else if (hasCredit) begin
            state          <= LINE;
            beatsRemaining <= PIX_W'(IMG_WIDTH);
          end
        end
        LINE: begin
          if (phaseEnd) begin
            state     <= WAIT;
            linesSent <= linesSent + LINE_W'(1);
          end
        end
        PAD_WAIT: begin
          if (padDone) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else if (hasCredit) begin
            state          <= PAD;
            beatsRemaining <= PIX_W'(IMG_WIDTH);
          end
        end
        PAD: begin
          if (phaseEnd) begin
            state   <= PAD_WAIT;
            padSent <= padSent + PAD_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  // Downstream back-pressure counter, restarted with each accepted frame.
  always_ff @(posedge axi_clk) begin
    if (axi_reset || (i_start && state == IDLE)) begin
      o_stall_cycles <= '0;
    end else if (o_data_valid && !i_data_ready && o_stall_cycles != '1) begin
      o_stall_cycles <= o_stall_cycles + 32'(1);
    end
  end
`endif

endmodule
